// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
// The master side offers words; the slave side serializes them.
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, word_done, busy
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-in, serial-out stage feeding the 1001 sequence detector.
// One shifting word plus a one-deep holding buffer allows gap-free streaming.
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_stream_serializer_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             xfer;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    // Ready depends only on registered state so the producer never sees a comb loop.
    assign xfer = bus.din_valid & ~hold_full;

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = SHIFT;
                    shreg_n = bus.din;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (hold_full) begin
                        shreg_n     = hold;
                        hold_full_n = 1'b0;
                    end else if (xfer) begin
                        shreg_n = bus.din;
                    end else begin
                        state_n = IDLE;
                        shreg_n = '0;
                    end
                end else begin
                    shreg_n = advance(shreg);
                    cnt_n   = cnt + CW'(1);
                    // A word arriving mid-shift waits in the holding register.
                    if (xfer) begin
                        hold_n      = bus.din;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
        end
    end

    assign bus.din_ready  = ~hold_full;
    assign bus.sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.sout_valid = (state == SHIFT);
    assign bus.word_done  = (state == SHIFT) && (cnt == LAST);
    assign bus.busy       = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: bit-queue stream model checked every cycle,
// plus directed vectors with literal expectations.
module tb_bit_stream_serializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_stream_serializer_if #(.WIDTH(8)) m ();
    bit_stream_serializer_if #(.WIDTH(8)) l ();

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(m.slave)
    );
    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .bus(l.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wd_cnt = 0;
    bit q[$];
    int qa[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the serial stream is the accepted words in order, each bit
    // becoming due one clock after its word was accepted, one bit per clock.
    always @(posedge clk) begin
        if (reset === 1'b1 && m.din_valid === 1'b1 && m.din_ready === 1'b1) begin
            for (int i = 0; i < 8; i++) begin
                q.push_back(m.din[7-i]);
                qa.push_back(cyc + 1);
            end
        end
        cyc++;
    end

    always @(negedge reset) begin
        q.delete();
        qa.delete();
    end

    always @(negedge clk) begin : cmp
        int words;
        bit ev;
        if (reset === 1'b1) begin
            words = (q.size() + 7) / 8;
            ev    = (q.size() > 0) && (qa[0] <= cyc);
            check("m_valid", m.sout_valid, ev);
            check("m_busy", m.busy, q.size() > 0);
            check("m_ready", m.din_ready, words < 2);
            if (ev) begin
                check("m_sout", m.sout, q[0]);
                check("m_done", m.word_done, (q.size() % 8) == 1);
                if (m.word_done === 1'b1) wd_cnt++;
                void'(q.pop_front());
                void'(qa.pop_front());
            end else begin
                check("m_sout_idle", m.sout, 0);
                check("m_done_idle", m.word_done, 0);
            end
        end
    end

    task automatic offer(input logic [7:0] w, output int waits);
        logic rdy;
        waits = 0;
        m.din_valid = 1'b1;
        while (1) begin
            rdy = m.din_ready;
            m.din = rdy ? w : 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                check("offer_timeout", waits, 0);
                break;
            end
        end
    endtask

    initial begin
        int w0, w1, w2;
        logic [7:0] exp;
        logic [7:0] lsb_words [2];
        lsb_words[0] = 8'h01;
        lsb_words[1] = 8'hB4;

        m.din = '0; m.din_valid = 1'b0;
        l.din = '0; l.din_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sout", m.sout, 0);
        check("rst_valid", m.sout_valid, 0);
        check("rst_done", m.word_done, 0);
        check("rst_busy", m.busy, 0);
        check("rst_ready", m.din_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single word 0x99, MSB first
        exp = 8'h99;
        offer(exp, w0);
        m.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_bit", m.sout, exp[7-i]);
            check("t1_vld", m.sout_valid, 1);
            check("t1_done", m.word_done, i == 7);
            @(negedge clk);
        end
        check("t1_idle_vld", m.sout_valid, 0);
        check("t1_idle_sout", m.sout, 0);
        repeat (2) @(negedge clk);

        // Back-to-back 0x09, 0x90
        offer(8'h09, w0);
        offer(8'h90, w1);
        m.din_valid = 1'b0;
        check("t2_ready_low", m.din_ready, 0);
        for (int i = 0; i < 15; i++) begin
            check("t2_nogap", m.sout_valid, 1);
            check("t2_ready", m.din_ready, i >= 7);
            @(negedge clk);
        end
        check("t2_end_vld", m.sout_valid, 0);
        repeat (2) @(negedge clk);

        // Three words offered continuously: third stalls
        offer(8'hA5, w0);
        offer(8'h3C, w1);
        offer(8'hFF, w2);
        m.din_valid = 1'b0;
        check("t3_wait0", w0, 0);
        check("t3_wait1", w1, 0);
        check("t3_wait2", w2, 7);
        repeat (24) @(negedge clk);
        check("t3_drained", q.size(), 0);
        check("t3_idle", m.busy, 0);

        // Idle gap of 3 cycles between two 0x99 words
        wd_cnt = 0;
        offer(8'h99, w0);
        m.din_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("t4_last", m.word_done, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_gap", m.sout_valid, 0);
        end
        offer(8'h99, w0);
        m.din_valid = 1'b0;
        check("t4_restart", m.sout_valid, 1);
        repeat (9) @(negedge clk);
        check("t4_done_cnt", wd_cnt, 2);

        // Asynchronous reset mid-word, then a fresh word
        offer(8'hF0, w0);
        m.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_sout", m.sout, 0);
        check("t5_valid", m.sout_valid, 0);
        check("t5_ready", m.din_ready, 1);
        check("t5_busy", m.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp = 8'h81;
        offer(exp, w0);
        m.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5_bit", m.sout, exp[7-i]);
            check("t5_done", m.word_done, i == 7);
            @(negedge clk);
        end
        check("t5_idle", m.sout_valid, 0);

        // LSB-first instance
        for (int k = 0; k < 2; k++) begin
            exp = lsb_words[k];
            l.din = exp;
            l.din_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            l.din_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check("t6_bit", l.sout, exp[i]);
                check("t6_vld", l.sout_valid, 1);
                check("t6_done", l.word_done, i == 7);
                @(negedge clk);
            end
            check("t6_idle", l.sout_valid, 0);
            check("t6_idle_sout", l.sout, 0);
        end

        repeat (2) @(negedge clk);
        check("model_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
